// File: rtl/bcd_counter.sv
// bcd_counter: synchronous multi-digit BCD up/down counter with validated
// parallel load and selectable wrap/saturate behaviour at the terminal counts.
// Every nibble of q stays within 0..9 once reset has been applied.
module bcd_counter #(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic         load_err_q, load_err_d;

    logic         load_ok;
    logic [W-1:0] inc_val, dec_val;
    logic         carry, borrow;
    logic [3:0]   digit;

    // A load is accepted only if every nibble of load_val is a decimal digit.
    always_comb begin
        load_ok = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    // Ripple carry/borrow across digits; the carry (borrow) left over after the
    // top digit means every digit was 9 (0), i.e. q sits at MAX (zero).
    always_comb begin
        inc_val = q_q;
        dec_val = q_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        digit   = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            digit = q_q[4*k +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    inc_val[4*k +: 4] = '0;
                end else begin
                    inc_val[4*k +: 4] = digit + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = digit - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Next-state selection: load beats count beats hold; terminal counts either
    // wrap (the ripple result already wraps) or hold in saturate mode.
    always_comb begin
        q_d        = q_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) q_d = load_val;
            else         load_err_d = 1'b1;
        end else if (en) begin
            if (up) begin
                tc_d = carry;
                if (!carry || WRAP) q_d = inc_val;
            end else begin
                tc_d = borrow;
                if (!borrow || WRAP) q_d = dec_val;
            end
        end
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = q_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule
